// File: rtl/fixed_pred_pkg.sv
// Shared constants, types and helpers for the FLAC fixed-predictor decoder.
package fixed_pred_pkg;

    localparam int MAX_ORDER = 4;

    typedef logic [2:0] order_t;

    // Coefficients applied to h1..h4 for each predictor order 0..4.
    localparam int COEF [0:MAX_ORDER][0:3] = '{
        '{ 0,  0,  0,  0},
        '{ 1,  0,  0,  0},
        '{ 2, -1,  0,  0},
        '{ 3, -3,  1,  0},
        '{ 4, -6,  4, -1}
    };

    // Accumulator width: room for the worst-case order-4 prediction or the residual, plus one.
    function automatic int acc_w(input int sample_w, input int resid_w);
        return (((sample_w + 4) > resid_w) ? (sample_w + 4) : resid_w) + 1;
    endfunction

endpackage

// File: rtl/fixed_pred_core.sv
// Combinational fixed-predictor datapath: prediction, residual add and range check.
module fixed_pred_core
    import fixed_pred_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int RESID_W  = 24
) (
    input  order_t              ord,
    input  logic                warm,
    input  logic [SAMPLE_W-1:0] h1,
    input  logic [SAMPLE_W-1:0] h2,
    input  logic [SAMPLE_W-1:0] h3,
    input  logic [SAMPLE_W-1:0] h4,
    input  logic [RESID_W-1:0]  resid,
    output logic [SAMPLE_W-1:0] result,
    output logic                range_err
);
    localparam int ACC_W = acc_w(SAMPLE_W, RESID_W);

    logic signed [ACC_W-1:0] h_ext [4];
    logic signed [ACC_W-1:0] pred  [MAX_ORDER+1];
    logic signed [ACC_W-1:0] pred_sel;
    logic signed [ACC_W-1:0] resid_ext;
    logic signed [ACC_W-1:0] sum;

    // Sign-extend history and residual into the accumulator width.
    always_comb begin
        h_ext[0]  = {{(ACC_W-SAMPLE_W){h1[SAMPLE_W-1]}}, h1};
        h_ext[1]  = {{(ACC_W-SAMPLE_W){h2[SAMPLE_W-1]}}, h2};
        h_ext[2]  = {{(ACC_W-SAMPLE_W){h3[SAMPLE_W-1]}}, h3};
        h_ext[3]  = {{(ACC_W-SAMPLE_W){h4[SAMPLE_W-1]}}, h4};
        resid_ext = {{(ACC_W-RESID_W){resid[RESID_W-1]}}, resid};
    end

    // Every order's prediction is formed in parallel from constant coefficients, then selected.
    always_comb begin
        for (int o = 0; o <= MAX_ORDER; o++) begin
            pred[o] = '0;
            for (int k = 0; k < 4; k++) begin
                pred[o] = pred[o] + signed'(ACC_W'(COEF[o][k])) * h_ext[k];
            end
        end
        case (ord)
            3'd1:    pred_sel = pred[1];
            3'd2:    pred_sel = pred[2];
            3'd3:    pred_sel = pred[3];
            3'd4:    pred_sel = pred[4];
            default: pred_sel = pred[0];
        endcase
    end

    // Warm-up samples pass through; the same fit check flags oversized warm-up values.
    always_comb begin
        sum       = warm ? resid_ext : (resid_ext + pred_sel);
        result    = sum[SAMPLE_W-1:0];
        range_err = !((&sum[ACC_W-1:SAMPLE_W-1]) || !(|sum[ACC_W-1:SAMPLE_W-1]));
    end

endmodule

// File: rtl/fixed_predictor_mc.sv
// Multi-channel FLAC fixed-predictor decoder: per-channel contexts plus one output register.
module fixed_predictor_mc
    import fixed_pred_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int RESID_W  = 24,
    parameter int CHANNELS = 2,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iValid,
    output logic                oReady,
    input  logic [CH_W-1:0]     iChannel,
    input  logic                iBlockStart,
    input  logic [2:0]          iOrder,
    input  logic [RESID_W-1:0]  iResidual,
    input  logic                iLast,
    output logic                oValid,
    input  logic                iReady,
    output logic [SAMPLE_W-1:0] oData,
    output logic [CH_W-1:0]     oChannel,
    output logic                oLast,
    output logic                oRangeErr
);
    order_t              order_q [CHANNELS];
    order_t              order_d [CHANNELS];
    logic [2:0]          warm_q  [CHANNELS];
    logic [2:0]          warm_d  [CHANNELS];
    logic [SAMPLE_W-1:0] h_q     [CHANNELS][4];
    logic [SAMPLE_W-1:0] h_d     [CHANNELS][4];

    logic [CHANNELS-1:0] ch_hit;
    order_t              order_sel, order_new, cur_order;
    logic [2:0]          warm_sel, cur_warm;
    logic [SAMPLE_W-1:0] h_sel [4];
    logic                accept, order_bad, in_warmup;
    logic [SAMPLE_W-1:0] core_result;
    logic                core_err;

    logic                valid_q, valid_d, last_q, last_d, err_q, err_d;
    logic [SAMPLE_W-1:0] data_q, data_d;
    logic [CH_W-1:0]     ch_q, ch_d;

    // One-hot decode of the incoming channel tag.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_hit
        assign ch_hit[gi] = (iChannel == CH_W'(gi));
    end

    // Fetch the addressed channel's context.
    always_comb begin
        order_sel = '0;
        warm_sel  = '0;
        for (int k = 0; k < 4; k++) h_sel[k] = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_hit[c]) begin
                order_sel = order_q[c];
                warm_sel  = warm_q[c];
                for (int k = 0; k < 4; k++) h_sel[k] = h_q[c][k];
            end
        end
    end

    // A block start overrides the stored order and warm-up count for this very beat.
    assign oReady    = !valid_q || iReady;
    assign accept    = iValid && oReady;
    assign order_bad = (iOrder > 3'(MAX_ORDER));
    assign order_new = order_bad ? order_t'(0) : iOrder;
    assign cur_order = iBlockStart ? order_new : order_sel;
    assign cur_warm  = iBlockStart ? 3'd0 : warm_sel;
    assign in_warmup = (cur_warm < cur_order);

    fixed_pred_core #(
        .SAMPLE_W (SAMPLE_W),
        .RESID_W  (RESID_W)
    ) u_core (
        .ord       (cur_order),
        .warm      (in_warmup),
        .h1        (h_sel[0]),
        .h2        (h_sel[1]),
        .h3        (h_sel[2]),
        .h4        (h_sel[3]),
        .resid     (iResidual),
        .result    (core_result),
        .range_err (core_err)
    );

    // Update only the accepted channel's context; history shifts on every accepted beat.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            order_d[c] = order_q[c];
            warm_d[c]  = warm_q[c];
            for (int k = 0; k < 4; k++) h_d[c][k] = h_q[c][k];
            if (accept && ch_hit[c]) begin
                order_d[c] = cur_order;
                warm_d[c]  = in_warmup ? (cur_warm + 3'd1) : cur_warm;
                h_d[c][3]  = h_q[c][2];
                h_d[c][2]  = h_q[c][1];
                h_d[c][1]  = h_q[c][0];
                h_d[c][0]  = core_result;
            end
        end
    end

    // Output register: load on accept, drop valid on consume, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        last_d  = last_q;
        err_d   = err_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = core_result;
            ch_d    = iChannel;
            last_d  = iLast;
            err_d   = err_q | core_err | (iBlockStart & order_bad);
        end else if (iReady) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                order_q[c] <= '0;
                warm_q[c]  <= '0;
                for (int k = 0; k < 4; k++) h_q[c][k] <= '0;
            end
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                order_q[c] <= order_d[c];
                warm_q[c]  <= warm_d[c];
                for (int k = 0; k < 4; k++) h_q[c][k] <= h_d[c][k];
            end
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign oValid    = valid_q;
    assign oData     = data_q;
    assign oChannel  = ch_q;
    assign oLast     = last_q;
    assign oRangeErr = err_q;

endmodule

// File: doc/fixed_predictor_mc.md
# fixed_predictor_mc

Parametrised, multi-channel FLAC fixed-predictor decoder. Accepts residual samples tagged with a channel number in any interleaving and reconstructs PCM samples using predictor orders 0–4. Each channel keeps its own history, warm-up counter and order. It sits between the residual (Rice) decoder and the channel-decorrelation / output stage, with valid/ready handshakes on both sides.

## Interface
- SAMPLE_W, 16: reconstructed sample width (two's complement).
- RESID_W, 24: residual input width (two's complement).
- CHANNELS, 2: number of independent channel contexts (1–8).
- CH_W, $clog2(CHANNELS) min 1: channel tag width.

Ports:
- iClock  in  1  clock; all state changes on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- iValid  in  1  input beat valid.
- oReady  out  1  block can accept an input beat.
- iChannel  in  CH_W  channel of the input beat.
- iBlockStart  in  1  beat is the first sample of a subframe for iChannel.
- iOrder  in  3  predictor order; sampled only when iBlockStart=1.
- iResidual  in  RESID_W  warm-up sample or residual.
- iLast  in  1  last sample of a subframe; passed through unchanged.
- oValid  out  1  output beat valid.
- iReady  in  1  downstream accepts the output beat.
- oData  out  SAMPLE_W  reconstructed sample.
- oChannel  out  CH_W  channel tag of oData.
- oLast  out  1  registered copy of iLast.
- oRangeErr  out  1  sticky error flag: an out-of-range result or an order greater than 4 was seen.

## Operation
- An input beat is accepted when iValid && oReady. An output beat is consumed when oValid && iReady.
- oReady = !oValid || iReady. This is a single output register with no skid.
- Per-channel state:
  - order[c], 3 bits.
  - warm[c], 3 bits.
  - history h1..h4 [c], SAMPLE_W each, where h1 is the most recent sample.
- Accepting a beat with iBlockStart=1 does the following for that channel:
  - Sets order[c] to iOrder.
  - Clears warm[c] to 0.
  - Processes the beat with the new values in the same cycle.
  - Other channels are untouched.
- If iOrder is greater than 4, order[c] is forced to 0 and oRangeErr is set.
- Reconstruction of an accepted beat on channel c:
  - If warm[c] < order[c]: the result is iResidual truncated to SAMPLE_W (a warm-up sample), and warm[c] increments.
  - Otherwise the result is iResidual + P, with P chosen by order:
    - Order 0: P = 0.
    - Order 1: P = h1.
    - Order 2: P = 2h1 − h2.
    - Order 3: P = 3h1 − 3h2 + h3.
    - Order 4: P = 4h1 − 6h2 + 4h3 − h4.
- Arithmetic width:
  - Sign-extend every operand to ACC_W = max(SAMPLE_W+4, RESID_W)+1.
  - The result is the low SAMPLE_W bits of the sum.
  - If the full sum does not fit in signed SAMPLE_W, oRangeErr is set.
  - Warm-up inputs that exceed SAMPLE_W also set oRangeErr.
- History shifts on every accepted beat, including warm-up beats: h4←h3, h3←h2, h2←h1, h1←result.
- History is updated at acceptance. A back-to-back beat on the same channel sees the updated history with no bubble.
- oRangeErr clears only on reset.
- A beat arriving without any prior iBlockStart on its channel uses the reset state: order 0, history 0.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on oData/oValid after edge N.
- Throughput is 1 sample per cycle while iReady=1.
- While oValid && !iReady:
  - oData, oChannel and oLast hold stable.
  - oReady is 0, so no state changes.
- iReady may go low in the same cycle a new beat is offered. In that case the beat is not accepted.
- Reset values: oValid=0, oData=0, oChannel=0, oLast=0, oRangeErr=0. All order, warm and history entries are 0.
- Reset asserted mid-stream discards the pending output beat. oValid is 0 on the next cycle.
- A simultaneous iBlockStart and a consume on the output behave independently. The output consume completes first in the same edge.
- Warm-up counter behaviour:
  - It saturates at order[c].
  - It never wraps.
  - It is not incremented by non-warm-up beats.

## Structure
- Package fixed_pred_pkg contains:
  - MAX_ORDER=4.
  - The order type (3-bit).
  - The predictor coefficient constants per order.
  - A function computing ACC_W.
- Sub-module fixed_pred_core is purely combinational. Inputs: order, warm-up flag, h1..h4, residual. Outputs: result and range-error. It is instantiated once.
- The top level holds the per-channel register banks (indexed by iChannel), the output register and the handshake logic.

## Test plan
- Channel 0, order 2. Beats 10, 20 (warm-up), then residuals 0, 1. Required oData: 10, 20, 30, 41.
- Interleaved channels, both order 1:
  - ch0: 100, +5.
  - ch1: −50, −3.
  - Sequence ch0, ch1, ch0, ch1.
  - Required oData: 100, −50, 105, −53. oChannel must match each beat.
- Order 4 with warm-up 1, 2, 3, 4, then residual 0. Required result 5. A following residual 0 gives 6.
- SAMPLE_W=16, order 1:
  - Warm-up 32767, then residual 1.
  - Required oData −32768 and oRangeErr=1.
  - oRangeErr stays 1 until reset.
- Backpressure: hold iReady=0 for 3 cycles with iValid=1.
  - oReady=0 during the stall.
  - oData is unchanged.
  - No beat is lost or duplicated after release.
  - A same-channel back-to-back order-1 sequence 1, 1, 1 yields 1, 2, 3.
- Reset mid-block, then iBlockStart on channel 0 with order 3 and warm-up samples 7, 7, 7. Required:
  - oValid=0 on the cycle after reset.
  - The three warm-up samples appear verbatim.
  - Residual 0 yields 7.
